// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and priority encoding for the register-file writeback arbiter
package regfile_pkg;

  localparam int DW = 16;
  localparam int IW = 3;

  localparam logic [IW-1:0] R_LIT = 3'd0;
  localparam logic [IW-1:0] R_A1  = 3'd1;
  localparam logic [IW-1:0] R_A2  = 3'd2;
  localparam logic [IW-1:0] R_A3  = 3'd3;
  localparam logic [IW-1:0] R_D1  = 3'd4;
  localparam logic [IW-1:0] R_OUT = 3'd5;
  localparam logic [IW-1:0] R_FP  = 3'd6;
  localparam logic [IW-1:0] R_SP  = 3'd7;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } pri_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rtl/regfile_wb_arbiter_rr_arb2.sv - two-way round-robin arbiter (bit 0 = ALU, bit 1 = load path)
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       hold_i,
  output logic [1:0] grant_o
);

  pri_e pri_q;
  pri_e pri_d;

  // Grant decode: a lone requester always wins; on contention the pointer side wins and the pointer moves to the loser
  always_comb begin
    grant_o = 2'b00;
    pri_d   = pri_q;
    if (!hold_i) begin
      case (req_i)
        2'b01: grant_o = 2'b01;
        2'b10: grant_o = 2'b10;
        2'b11: begin
          if (pri_q == PRI_ALU) begin
            grant_o = 2'b01;
            pri_d   = PRI_MEM;
          end else begin
            grant_o = 2'b10;
            pri_d   = PRI_ALU;
          end
        end
        default: grant_o = 2'b00;
      endcase
    end
  end

  // Priority pointer flop; ALU has priority out of reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pri_q <= PRI_ALU;
    end else begin
      pri_q <= pri_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register file write port between ALU and load paths (optional REGWB_BYPASS_EN forwarding)
module regfile_wb_arbiter #(
  parameter int DW     = regfile_pkg::DW,
  parameter int IW     = regfile_pkg::IW,
  parameter bit LIT_WE = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_req,
  input  logic [IW-1:0] alu_idx,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ack,
  input  logic          mem_req,
  input  logic [IW-1:0] mem_idx,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ack,
  input  logic          wb_hold,
`ifdef REGWB_BYPASS_EN
  input  logic [IW-1:0] byp_idx1,
  input  logic [IW-1:0] byp_idx2,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  output logic [DW-1:0] byp_data1,
  output logic [DW-1:0] byp_data2,
`endif
  output logic          rf_we,
  output logic [IW-1:0] rf_widx,
  output logic [DW-1:0] rf_wdata,
  output logic [15:0]   conflict_cnt
);

  logic [1:0]    grant;
  logic [IW-1:0] win_idx;
  logic [DW-1:0] win_data;
  logic          drop;
  logic          contended;

  logic          rf_we_q, rf_we_d;
  logic [IW-1:0] rf_widx_q, rf_widx_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic [15:0]   cnt_q, cnt_d;

  // Reset also acts as a hold so nothing is acknowledged while the block is being reset
  rr_arb2 u_arb (
    .clk_i   (clk),
    .reset_i (reset),
    .req_i   ({mem_req, alu_req}),
    .hold_i  (wb_hold | reset),
    .grant_o (grant)
  );

  assign alu_ack   = grant[0];
  assign mem_ack   = grant[1];
  assign contended = alu_req & mem_req & ~wb_hold;

  // Select the winning request and decide whether a write to the literal register is swallowed
  always_comb begin
    win_idx  = grant[1] ? mem_idx  : alu_idx;
    win_data = grant[1] ? mem_data : alu_data;
    drop     = (LIT_WE == 1'b0) && (win_idx == IW'(regfile_pkg::R_LIT));
  end

  // Next write-port state: a kept grant writes, otherwise rf_we drops and index/data hold
  always_comb begin
    rf_we_d    = 1'b0;
    rf_widx_d  = rf_widx_q;
    rf_wdata_d = rf_wdata_q;
    if ((grant != 2'b00) && !drop) begin
      rf_we_d    = 1'b1;
      rf_widx_d  = win_idx;
      rf_wdata_d = win_data;
    end
  end

  // Saturating contention counter next value
  always_comb begin
    cnt_d = cnt_q;
    if (contended && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Registered write port and debug counter; reset discards any write in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_widx_q  <= '0;
      rf_wdata_q <= '0;
      cnt_q      <= 16'd0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_widx_q  <= rf_widx_d;
      rf_wdata_q <= rf_wdata_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_widx      = rf_widx_q;
  assign rf_wdata     = rf_wdata_q;
  assign conflict_cnt = cnt_q;

`ifdef REGWB_BYPASS_EN
  // Forward the write that commits on the coming edge to readers of the same register
  always_comb begin
    byp_data1 = (rf_we_q && (rf_widx_q == byp_idx1)) ? rf_wdata_q : rf_rdata1;
    byp_data2 = (rf_we_q && (rf_widx_q == byp_idx2)) ? rf_wdata_q : rf_rdata2;
  end
`endif

endmodule
